lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 33 +++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu.sv | 136 +++++++++++++
 tb/tb_lsu.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU encodings: width-select codes (common with the mem stage) and FSM states.
package lsu_op_enum;

  typedef enum logic [2:0] {
    SEL_B  = 3'b000,
    SEL_H  = 3'b001,
    SEL_W  = 3'b010,
    SEL_BU = 3'b100,
    SEL_HU = 3'b101
  } sel_e;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    WAIT0,
    ISSUE1,
    WAIT1,
    RESP
  } state_e;

  function automatic logic sel_legal(input logic [2:0] sel);
    case (sel)
      SEL_B, SEL_H, SEL_W, SEL_BU, SEL_HU: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  // H at an odd byte or W off a word boundary.
  function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] off);
    return ((sel[1:0] == 2'b01) && off[0]) || ((sel[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// LSU alignment: store byte-enable/data lane shifting and load extract plus sign/zero extension.
module lsu_align
  import lsu_op_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      sel,
  input  logic [1:0]      off,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata0,
  input  logic [XLEN-1:0] rdata1,
  output logic [3:0]      be0,
  output logic [3:0]      be1,
  output logic [XLEN-1:0] wdata0,
  output logic [XLEN-1:0] wdata1,
  output logic [XLEN-1:0] load_data
);

  logic [3:0]      base;
  logic [4:0]      sh;
  logic [5:0]      sh_rev;
  logic [XLEN-1:0] ld;

  always_comb begin
    case (sel[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    sh     = {off, 3'b000};
    sh_rev = 6'(XLEN) - {1'b0, sh};
    // Shifts of the full width yield zero, so offset 0 leaves beat 1 empty.
    be0    = base << off;
    be1    = base >> (3'd4 - {1'b0, off});
    wdata0 = wdata << sh;
    wdata1 = wdata >> sh_rev;
    ld     = (rdata0 >> sh) | (rdata1 << sh_rev);
  end

  always_comb begin
    case (sel)
      SEL_B:   load_data = {{(XLEN-8){ld[7]}}, ld[7:0]};
      SEL_BU:  load_data = {{(XLEN-8){1'b0}}, ld[7:0]};
      SEL_H:   load_data = {{(XLEN-16){ld[15]}}, ld[15:0]};
      SEL_HU:  load_data = {{(XLEN-16){1'b0}}, ld[15:0]};
      default: load_data = ld;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// LSU: turns byte/half/word load/store requests into word-aligned bus beats.
// LSU_MISALIGN_EN: when defined, word-crossing H/W accesses split into two beats; otherwise they fault.
module lsu
  import lsu_op_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_wr_i,
  input  logic [2:0]      req_sel_i,
  input  logic [XLEN-1:0] req_addr_i,
  input  logic [XLEN-1:0] req_wdata_i,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_rdata_o,
  output logic            rsp_err_o,
  output logic            bus_valid_o,
  input  logic            bus_ready_i,
  output logic            bus_we_o,
  output logic [XLEN-1:0] bus_addr_o,
  output logic [3:0]      bus_be_o,
  output logic [XLEN-1:0] bus_wdata_o,
  input  logic            bus_rvalid_i,
  input  logic [XLEN-1:0] bus_rdata_i
);

  state_e          state_q, state_d;
  logic            wr_q, err_q;
  logic [2:0]      sel_q;
  logic [XLEN-1:0] addr_q, wdata_q, rdata0_q, rdata1_q, rsp_rdata_q;
  logic [XLEN-3:0] word_q;
  logic            accept, req_fault, split;
  logic [3:0]      be0, be1;
  logic [XLEN-1:0] wdata0, wdata1, ld_data, ld_in0, ld_in1;

  assign accept = req_valid_i & req_ready_o;
  assign word_q = addr_q[XLEN-1:2];

`ifdef LSU_MISALIGN_EN
  assign req_fault = !sel_legal(req_sel_i);
  assign split     = |be1;
`else
  assign req_fault = !sel_legal(req_sel_i) || misaligned(req_sel_i, req_addr_i[1:0]);
  assign split     = 1'b0;
`endif

  // The final beat's data is still on the bus at the edge into RESP.
  assign ld_in0 = (state_q == WAIT0) ? bus_rdata_i : rdata0_q;
  assign ld_in1 = (state_q == WAIT1) ? bus_rdata_i : rdata1_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .sel       (sel_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rdata0    (ld_in0),
    .rdata1    (ld_in1),
    .be0       (be0),
    .be1       (be1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .load_data (ld_data)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      sel_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wr_q    <= req_wr_i;
        sel_q   <= req_sel_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        err_q   <= req_fault;
      end
      if (state_q == WAIT0 && bus_rvalid_i) rdata0_q <= bus_rdata_i;
      if (state_q == WAIT1 && bus_rvalid_i) rdata1_q <= bus_rdata_i;
      if (state_d == RESP && state_q != RESP)
        rsp_rdata_q <= (state_q == WAIT0 || state_q == WAIT1) ? ld_data : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = req_fault ? RESP : ISSUE0;
      ISSUE0:  if (bus_ready_i) state_d = !wr_q ? WAIT0 : (split ? ISSUE1 : RESP);
      WAIT0:   if (bus_rvalid_i) state_d = split ? ISSUE1 : RESP;
      ISSUE1:  if (bus_ready_i) state_d = wr_q ? RESP : WAIT1;
      WAIT1:   if (bus_rvalid_i) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == IDLE) && !rst_i;
    bus_valid_o = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = '0;
    bus_wdata_o = '0;
    case (state_q)
      ISSUE0: begin
        bus_valid_o = 1'b1;
        bus_we_o    = wr_q;
        bus_addr_o  = {word_q, 2'b00};
        bus_be_o    = be0;
        bus_wdata_o = wr_q ? wdata0 : '0;
      end
      ISSUE1: begin
        bus_valid_o = 1'b1;
        bus_we_o    = wr_q;
        bus_addr_o  = {word_q + (XLEN-2)'(1), 2'b00};
        bus_be_o    = be1;
        bus_wdata_o = wr_q ? wdata1 : '0;
      end
      default: ;
    endcase
  end

  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = (state_q == RESP) && err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table plus reset-in-flight sequence.
module tb_lsu;
  import lsu_op_enum::*;

  logic        clk = 1'b0;
  logic        rst_i, req_valid_i, req_ready_o, req_wr_i;
  logic [2:0]  req_sel_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        rsp_valid_o, rsp_err_o;
  logic [31:0] rsp_rdata_o;
  logic        bus_valid_o, bus_ready_i, bus_we_o, bus_rvalid_i;
  logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
  logic [3:0]  bus_be_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu #(.XLEN(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_wr_i     (req_wr_i),
    .req_sel_i    (req_sel_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .bus_valid_o  (bus_valid_o),
    .bus_ready_i  (bus_ready_i),
    .bus_we_o     (bus_we_o),
    .bus_addr_o   (bus_addr_o),
    .bus_be_o     (bus_be_o),
    .bus_wdata_o  (bus_wdata_o),
    .bus_rvalid_i (bus_rvalid_i),
    .bus_rdata_i  (bus_rdata_i)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [2:0]  sel;
    logic [31:0] addr, wdata, rd0, rd1;
    int          stall;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] w0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] w1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic wr, logic [2:0] sel, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] rd0, logic [31:0] rd1, int stall,
                              int lat, logic [31:0] rdata, logic err, int beats,
                              logic [31:0] a0, logic [3:0] be0, logic [31:0] w0,
                              logic [31:0] a1, logic [3:0] be1, logic [31:0] w1);
    vec_t v;
    v.name = name; v.wr = wr; v.sel = sel; v.addr = addr; v.wdata = wdata;
    v.rd0 = rd0; v.rd1 = rd1; v.stall = stall; v.lat = lat; v.rdata = rdata;
    v.err = err; v.beats = beats; v.a0 = a0; v.be0 = be0; v.w0 = w0;
    v.a1 = a1; v.be1 = be1; v.w1 = w1;
    return v;
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Drives one request and acts as the bus slave; records what the DUT presented.
  task automatic run_txn(input vec_t v);
    logic [31:0] ba[2], bw[2];
    logic [3:0]  bb[2];
    logic        bwe[2];
    logic [31:0] got_rd;
    logic        got_err;
    int          hs = 0, lat = -1, stall_left = v.stall, rd_idx = 0;
    bit          pend = 0, seen = 0, done = 0, unstable = 0, ready_bad = 0;
    ba[0] = '0; ba[1] = '0; bw[0] = '0; bw[1] = '0; bb[0] = '0; bb[1] = '0;
    bwe[0] = 1'b0; bwe[1] = 1'b0; got_rd = '0; got_err = 1'b0;

    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = v.wr; req_sel_i = v.sel;
    req_addr_i = v.addr; req_wdata_i = v.wdata;
    chk(v.name, "ready_idle", 32'(req_ready_o), 32'd1);
    @(negedge clk);
    req_valid_i = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      bus_rvalid_i = pend;
      bus_rdata_i  = (rd_idx == 0) ? v.rd0 : v.rd1;
      pend = 0;
      bus_ready_i = 1'b0;
      if (req_ready_o) ready_bad = 1;
      if (rsp_valid_o) begin
        lat = c; got_rd = rsp_rdata_o; got_err = rsp_err_o; done = 1;
      end else if (bus_valid_o && hs < 2) begin
        if (!seen) begin
          ba[hs] = bus_addr_o; bb[hs] = bus_be_o; bw[hs] = bus_wdata_o; bwe[hs] = bus_we_o; seen = 1;
        end else if (ba[hs] !== bus_addr_o || bb[hs] !== bus_be_o ||
                     bw[hs] !== bus_wdata_o || bwe[hs] !== bus_we_o) begin
          unstable = 1;
        end
        if (stall_left > 0) stall_left--;
        else begin
          bus_ready_i = 1'b1;
          if (!bus_we_o) begin pend = 1; rd_idx = hs; end
          hs++; seen = 0;
        end
      end
      if (!done) @(negedge clk);
    end
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;

    chk(v.name, "latency", 32'(lat), 32'(v.lat));
    chk(v.name, "rdata", got_rd, v.rdata);
    chk(v.name, "err", 32'(got_err), 32'(v.err));
    chk(v.name, "beats", 32'(hs), 32'(v.beats));
    chk(v.name, "ready_busy", 32'(ready_bad), 32'd0);
    if (v.beats >= 1) begin
      chk(v.name, "addr0", ba[0], v.a0);
      chk(v.name, "be0", 32'(bb[0]), 32'(v.be0));
      chk(v.name, "we0", 32'(bwe[0]), 32'(v.wr));
      if (v.wr) chk(v.name, "wdata0", bw[0], v.w0);
    end
    if (v.beats == 2) begin
      chk(v.name, "addr1", ba[1], v.a1);
      chk(v.name, "be1", 32'(bb[1]), 32'(v.be1));
      if (v.wr) chk(v.name, "wdata1", bw[1], v.w1);
    end
    if (v.stall > 0) chk(v.name, "stable", 32'(unstable), 32'd0);

    @(negedge clk);
    chk(v.name, "pulse_end", 32'(rsp_valid_o), 32'd0);
    chk(v.name, "ready_after", 32'(req_ready_o), 32'd1);
    chk(v.name, "rdata_hold", rsp_rdata_o, got_rd);
  endtask

  initial begin
    rst_i = 1'b1; req_valid_i = 1'b1; req_wr_i = 1'b0; req_sel_i = 3'b010;
    req_addr_i = 32'h100; req_wdata_i = '0;
    bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;

    vecs.push_back(mk("sw_aligned", 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, 0, 2, 0, 0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk("lb_sign", 0, 3'b000, 32'h103, 0, 32'h80112233, 0, 0, 3, 32'hFFFFFF80, 0, 1, 32'h100, 4'b1000, 0, 0, 0, 0));
    vecs.push_back(mk("lbu_zero", 0, 3'b100, 32'h103, 0, 32'h80112233, 0, 0, 3, 32'h00000080, 0, 1, 32'h100, 4'b1000, 0, 0, 0, 0));
    vecs.push_back(mk("lh_sign", 0, 3'b001, 32'h102, 0, 32'h80112233, 0, 0, 3, 32'hFFFF8011, 0, 1, 32'h100, 4'b1100, 0, 0, 0, 0));
    vecs.push_back(mk("lhu_low", 0, 3'b101, 32'h100, 0, 32'h80112233, 0, 0, 3, 32'h00002233, 0, 1, 32'h100, 4'b0011, 0, 0, 0, 0));
    vecs.push_back(mk("lw_aligned", 0, 3'b010, 32'h200, 0, 32'h12345678, 0, 0, 3, 32'h12345678, 0, 1, 32'h200, 4'b1111, 0, 0, 0, 0));
    vecs.push_back(mk("sb_off1", 1, 3'b000, 32'h101, 32'h000000A5, 0, 0, 0, 2, 0, 0, 1, 32'h100, 4'b0010, 32'h0000A500, 0, 0, 0));
    vecs.push_back(mk("sh_off2", 1, 3'b001, 32'h106, 32'h0000BEEF, 0, 0, 0, 2, 0, 0, 1, 32'h104, 4'b1100, 32'hBEEF0000, 0, 0, 0));
    vecs.push_back(mk("sel_011", 0, 3'b011, 32'h100, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sel_111", 1, 3'b111, 32'h100, 32'h1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sw_stall5", 1, 3'b010, 32'h100, 32'h01020304, 0, 0, 5, 7, 0, 0, 1, 32'h100, 4'b1111, 32'h01020304, 0, 0, 0));
`ifdef LSU_MISALIGN_EN
    vecs.push_back(mk("lw_split", 0, 3'b010, 32'h101, 0, 32'h44332211, 32'h88776655, 0, 5, 32'h55443322, 0, 2, 32'h100, 4'b1110, 0, 32'h104, 4'b0001, 0));
    vecs.push_back(mk("lh_off1", 0, 3'b001, 32'h101, 0, 32'h44332211, 0, 0, 3, 32'h00003322, 0, 1, 32'h100, 4'b0110, 0, 0, 0, 0));
    vecs.push_back(mk("sw_split", 1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 0, 0, 3, 0, 0, 2, 32'h100, 4'b1100, 32'hCCDD0000, 32'h104, 4'b0011, 32'h0000AABB));
    vecs.push_back(mk("lh_split", 0, 3'b001, 32'h103, 0, 32'h80112233, 32'h000000FF, 0, 5, 32'hFFFFFF80, 0, 2, 32'h100, 4'b1000, 0, 32'h104, 4'b0001, 0));
`else
    vecs.push_back(mk("lw_mis_fault", 0, 3'b010, 32'h101, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lh_odd_fault", 0, 3'b001, 32'h101, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("sw_mis_fault", 1, 3'b010, 32'h102, 32'hAABBCCDD, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("lh_x_fault", 0, 3'b001, 32'h103, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
`endif

    // Outputs while reset is held (a pending request must not be accepted).
    repeat (2) @(negedge clk);
    chk("reset", "req_ready", 32'(req_ready_o), 32'd0);
    chk("reset", "bus_valid", 32'(bus_valid_o), 32'd0);
    chk("reset", "rsp", {29'd0, rsp_valid_o, rsp_err_o, bus_we_o}, 32'd0);
    chk("reset", "rsp_rdata", rsp_rdata_o, 32'd0);
    chk("reset", "bus_addr", bus_addr_o, 32'd0);
    chk("reset", "bus_wdata", bus_wdata_o, 32'd0);
    chk("reset", "bus_be", 32'(bus_be_o), 32'd0);
    rst_i = 1'b0; req_valid_i = 1'b0;
    #1 chk("reset", "ready_release", 32'(req_ready_o), 32'd1);

    foreach (vecs[i]) run_txn(vecs[i]);

    // Reset while waiting for load data; the late rvalid must be ignored.
    @(negedge clk);
    req_valid_i = 1'b1; req_wr_i = 1'b0; req_sel_i = 3'b010; req_addr_i = 32'h300;
    @(negedge clk);
    req_valid_i = 1'b0; bus_ready_i = 1'b1;
    chk("rst_wait", "issue", 32'(bus_valid_o), 32'd1);
    @(negedge clk);
    bus_ready_i = 1'b0;
    chk("rst_wait", "in_wait", {30'd0, bus_valid_o, req_ready_o}, 32'd0);
    rst_i = 1'b1;
    #1 chk("rst_wait", "rsp_in_rst", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 32'hCAFEF00D;
    #1 chk("rst_wait", "ready_after", 32'(req_ready_o), 32'd1);
    chk("rst_wait", "rsp_late", 32'(rsp_valid_o), 32'd0);
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    chk("rst_wait", "no_rsp", 32'(rsp_valid_o), 32'd0);
    chk("rst_wait", "idle", {30'd0, bus_valid_o, req_ready_o}, 32'd1);
    chk("rst_wait", "rdata", rsp_rdata_o, 32'd0);
    run_txn(vecs[1]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
